// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss/refill controller: one outstanding refill, victim is the
// lowest invalid way or an LFSR-chosen way, with kill/drain of in-flight requests.
module icache_refill_ctrl #(
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 20,
  parameter int LINE_W = 128
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   miss_valid_i,
  output logic                   miss_ready_o,
  input  logic [IDX_W-1:0]       miss_idx_i,
  input  logic [TAG_W-1:0]       miss_tag_i,
  input  logic [3:0]             valid_bits_i,
  input  logic                   kill_i,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic [TAG_W+IDX_W-1:0] mem_req_addr_o,
  input  logic                   mem_rsp_valid_i,
  input  logic [LINE_W-1:0]      mem_rsp_data_i,
  output logic                   fill_valid_o,
  output logic [1:0]             fill_way_o,
  output logic [IDX_W-1:0]       fill_idx_o,
  output logic [TAG_W-1:0]       fill_tag_o,
  output logic [LINE_W-1:0]      fill_data_o,
  output logic                   busy_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    FILL  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_lfsr;
  logic [IDX_W-1:0]  r_idx;
  logic [TAG_W-1:0]  r_tag;
  logic [1:0]        r_way;
  logic [1:0]        r_fill_way;
  logic [IDX_W-1:0]  r_fill_idx;
  logic [TAG_W-1:0]  r_fill_tag;
  logic [LINE_W-1:0] r_fill_data;
  logic [1:0]        w_victim;
  logic              w_accept;
  logic              w_all_valid;
  logic              w_fill_load;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ~(q[7] ^ q[3] ^ q[2] ^ q[1])};
  endfunction

  assign miss_ready_o = (r_state == IDLE) && !kill_i;
  assign w_accept     = miss_valid_i && miss_ready_o;
  assign w_all_valid  = &valid_bits_i;

  // Victim: lowest invalid way, else the pseudo-random way
  always_comb begin
    w_victim = r_lfsr[1:0];
    if (!valid_bits_i[0]) begin
      w_victim = 2'd0;
    end else if (!valid_bits_i[1]) begin
      w_victim = 2'd1;
    end else if (!valid_bits_i[2]) begin
      w_victim = 2'd2;
    end else if (!valid_bits_i[3]) begin
      w_victim = 2'd3;
    end else begin
      w_victim = r_lfsr[1:0];
    end
  end

  // Next-state decode; a kill that coincides with a completed handshake must drain the response
  always_comb begin
    w_state_nxt = r_state;
    w_fill_load = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = REQ;
        else          w_state_nxt = IDLE;
      end
      REQ: begin
        if (kill_i && mem_req_ready_i) w_state_nxt = DRAIN;
        else if (kill_i)               w_state_nxt = IDLE;
        else if (mem_req_ready_i)      w_state_nxt = WAIT;
        else                           w_state_nxt = REQ;
      end
      WAIT: begin
        if (mem_rsp_valid_i && kill_i) begin
          w_state_nxt = IDLE;
        end else if (mem_rsp_valid_i) begin
          w_state_nxt = FILL;
          w_fill_load = 1'b1;
        end else if (kill_i) begin
          w_state_nxt = DRAIN;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      DRAIN: begin
        if (mem_rsp_valid_i) w_state_nxt = IDLE;
        else                 w_state_nxt = DRAIN;
      end
      FILL:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Miss capture and LFSR advance, only when the LFSR actually chose the victim
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lfsr <= 8'h00;
      r_idx  <= '0;
      r_tag  <= '0;
      r_way  <= 2'd0;
    end else if (w_accept) begin
      r_idx  <= miss_idx_i;
      r_tag  <= miss_tag_i;
      r_way  <= w_victim;
      r_lfsr <= w_all_valid ? lfsr_next(r_lfsr) : r_lfsr;
    end else begin
      r_lfsr <= r_lfsr;
    end
  end

  // Fill payload is held separately so it stays stable after the next miss is accepted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fill_way  <= 2'd0;
      r_fill_idx  <= '0;
      r_fill_tag  <= '0;
      r_fill_data <= '0;
    end else if (w_fill_load) begin
      r_fill_way  <= r_way;
      r_fill_idx  <= r_idx;
      r_fill_tag  <= r_tag;
      r_fill_data <= mem_rsp_data_i;
    end else begin
      r_fill_way  <= r_fill_way;
    end
  end

  assign mem_req_valid_o = (r_state == REQ);
  assign mem_req_addr_o  = {r_tag, r_idx};
  assign fill_valid_o    = (r_state == FILL);
  assign fill_way_o      = r_fill_way;
  assign fill_idx_o      = r_fill_idx;
  assign fill_tag_o      = r_fill_tag;
  assign fill_data_o     = r_fill_data;
  assign busy_o          = (r_state != IDLE);

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Instruction-cache miss/refill controller for the 4-way set-associative icache. It accepts one miss at a time and picks the victim way: the lowest invalid way if one exists, otherwise a pseudo-random way from an internal 8-bit LFSR. It then issues the line request to memory, waits for the line and drives a one-cycle fill write into the tag/data arrays. It sits between the icache lookup stage and the memory interface, and supports kill/flush of an in-flight refill.

## Interface
- IDX_W, 6, set index width
- TAG_W, 20, tag width
- LINE_W, 128, cache line width in bits
- N_WAY is fixed at 4; the way field is 2 bits.

- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- miss_valid_i  in  1  lookup stage presents a miss
- miss_ready_o  out  1  controller can accept a miss
- miss_idx_i  in  IDX_W  set index of the miss
- miss_tag_i  in  TAG_W  tag of the miss
- valid_bits_i  in  4  valid bits of the indexed set; sampled at acceptance
- kill_i  in  1  abort the current or pending refill
- mem_req_valid_o  out  1  line request valid
- mem_req_ready_i  in  1  memory accepts the request
- mem_req_addr_o  out  TAG_W+IDX_W  line address {tag, idx}
- mem_rsp_valid_i  in  1  line data returned (one beat)
- mem_rsp_data_i  in  LINE_W  line data
- fill_valid_o  out  1  write strobe to the tag/data arrays, one cycle
- fill_way_o  out  2  way to write
- fill_idx_o  out  IDX_W  set to write
- fill_tag_o  out  TAG_W  tag to write
- fill_data_o  out  LINE_W  line to write
- busy_o  out  1  controller is not IDLE

## Operation
- States are IDLE, REQ, WAIT, DRAIN and FILL.
- **Acceptance**
  - miss_ready_o = (state==IDLE) && !kill_i.
  - A miss is accepted when miss_valid_i && miss_ready_o.
  - On acceptance, the controller registers idx, tag and the victim way, then goes to REQ.
- **Victim selection** (combinational from valid_bits_i at acceptance)
  - If any valid bit is 0, the victim is the lowest-numbered invalid way.
  - If all four bits are 1, the victim is lfsr_q[1:0].
- **LFSR**
  - 8-bit register, reset value 0x00.
  - Next value = {q[6:0], ~(q[7]^q[3]^q[2]^q[1])}.
  - Advances only on an acceptance cycle whose victim came from the LFSR (all valid); otherwise it holds.
- **REQ**
  - mem_req_valid_o=1 with mem_req_addr_o={tag,idx}, held stable until mem_req_ready_i.
  - Handshake without kill -> WAIT.
  - kill_i with mem_req_ready_i=0 -> IDLE; the request is withdrawn.
  - kill_i with mem_req_ready_i=1 -> DRAIN; the handshake has completed.
- **WAIT**
  - mem_rsp_valid_i -> FILL, with mem_rsp_data_i captured.
  - kill_i without mem_rsp_valid_i -> DRAIN.
  - kill_i with mem_rsp_valid_i -> IDLE, with no fill.
- **DRAIN**
  - Waits for mem_rsp_valid_i, discards the data, then -> IDLE. No fill is issued.
  - kill_i has no further effect.
- **FILL**
  - fill_valid_o=1 for exactly one cycle; fill_way/idx/tag/data carry the registered values.
  - kill_i is ignored and the write completes. Next state is IDLE.
- mem_rsp_valid_i in IDLE, REQ or FILL is a protocol violation and is ignored; it never changes state.
- The fill_* payload outputs hold their last values outside FILL; only fill_valid_o qualifies them.

## Timing
- **Reset values:** state IDLE, lfsr 0x00, miss_ready_o=1 (if kill_i=0), mem_req_valid_o=0, fill_valid_o=0, busy_o=0, fill_way_o=0, fill_idx_o=0, fill_tag_o=0, fill_data_o=0, mem_req_addr_o=0.
- Reset mid-refill returns to IDLE immediately. A response arriving after reset is ignored; the memory side is reset by the same rst_ni.
- **Best-case latency** (miss accepted in cycle T, request ready immediately, response in the next cycle):
  - T+1: mem_req_valid_o.
  - T+2: response may arrive.
  - T+3: fill_valid_o.
  - T+4: miss_ready_o=1 again.
- One refill is outstanding at most. There is no back-to-back acceptance while busy_o=1.
- All outputs are registered-state decodes, except miss_ready_o, which depends combinationally on kill_i.

## Test plan
- **Invalid-way fill:** valid_bits_i=4'b1011, miss idx 0x05, tag 0xABCDE, req ready at T+1, rsp at T+2 with data D.
  - fill_valid_o at T+3 with way=2, idx=0x05, tag=0xABCDE, data D.
  - mem_req_addr_o={0xABCDE,0x05}.
  - LFSR unchanged.
- **Random replacement sequence:** after reset, four misses each with valid_bits_i=4'hF.
  - fill_way_o sequence is 0,1,3,2.
  - LFSR values are 0x01, 0x03, 0x06, 0x0D after each respective acceptance.
- **Mixed LFSR hold:** alternate all-valid misses with valid_bits_i=4'b0111 misses.
  - The partially-valid misses fill way 3 and do not advance the LFSR.
  - The all-valid ways still follow 0,1,3,2.
- **Kill in REQ before ready:** mem_req_ready_i held 0, kill_i pulsed in REQ.
  - Next cycle IDLE, mem_req_valid_o=0, no fill.
  - A later response is ignored.
- **Kill in WAIT:** kill_i pulsed, response arrives 3 cycles later.
  - State DRAIN, then IDLE one cycle after the response.
  - fill_valid_o never asserts; miss_ready_o=1 afterwards.
- **Kill/ready and kill/miss collisions:**
  - kill_i with mem_req_ready_i=1 leads to DRAIN and exactly one response is consumed.
  - kill_i with miss_valid_i in IDLE keeps miss_ready_o=0 and the miss is not accepted.
  - Async reset asserted during WAIT gives all outputs their reset values within the reset cycle.
